// File: rtl/maxpool_accum.sv
// maxpool_accum
// Multi-channel pooling accumulator placed after the PE-array result bus.
// Reduces a window of 2^len consecutive beats to one pooled beat per channel
// (max, floor-average, or bypass). Windows are counted internally.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_mode      00 bypass, 01 max, 10 average, 11 bypass
//   i_win_log2  window length exponent, clamped to MAX_LOG2
//   i_valid     input beat strobe (always accepted)
//   i_data      CH packed signed elements, channel c at [c*DATA_W +: DATA_W]
//   i_flush     drop the partial window (and any same-cycle beat)
//   o_valid     one-cycle pulse per pooled beat
//   o_data      pooled beat, same packing as i_data, held between pulses
//   o_busy      a window is partially accumulated
module maxpool_accum #(
    parameter int DATA_W   = 32,
    parameter int CH       = 4,
    parameter int MAX_LOG2 = 4,
    localparam int LOG_W   = $clog2(MAX_LOG2 + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_mode,
    input  logic [LOG_W-1:0]     i_win_log2,
    input  logic                 i_valid,
    input  logic [CH*DATA_W-1:0] i_data,
    input  logic                 i_flush,
    output logic                 o_valid,
    output logic [CH*DATA_W-1:0] o_data,
    output logic                 o_busy
);

    localparam int ACC_W = DATA_W + MAX_LOG2;
    localparam int CNT_W = MAX_LOG2 + 1;

    logic signed [ACC_W-1:0] acc     [CH];
    logic signed [ACC_W-1:0] din_x   [CH];
    logic signed [ACC_W-1:0] nxt_acc [CH];
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              mode_q;
    logic [LOG_W-1:0]        len_q;

    logic [LOG_W-1:0]        cfg_len;
    logic [LOG_W-1:0]        eff_len;
    logic [1:0]              eff_mode;
    logic [CNT_W-1:0]        lim;
    logic                    first;
    logic                    bypass;
    logic                    is_avg;
    logic                    last;
    logic [CH*DATA_W-1:0]    res;

    // On the first beat of a window the live config applies; afterwards the
    // latched copy does, so mid-window config changes have no effect.
    always_comb begin
        cfg_len  = (i_win_log2 > LOG_W'(MAX_LOG2)) ? LOG_W'(MAX_LOG2) : i_win_log2;
        first    = (cnt == '0);
        eff_mode = first ? i_mode : mode_q;
        eff_len  = first ? cfg_len : len_q;
        bypass   = (eff_mode == 2'b00) || (eff_mode == 2'b11);
        is_avg   = (eff_mode == 2'b10);
        lim      = (CNT_W'(1) << eff_len) - CNT_W'(1);
        last     = (cnt == lim);
        res      = '0;
        for (int c = 0; c < CH; c++) begin
            din_x[c] = ACC_W'($signed(i_data[c*DATA_W +: DATA_W]));
            // First beat loads unconditionally so all-negative windows pool
            // correctly without comparing against stale or zero state.
            if (first)
                nxt_acc[c] = din_x[c];
            else if (is_avg)
                nxt_acc[c] = acc[c] + din_x[c];
            else if (din_x[c] > acc[c])
                nxt_acc[c] = din_x[c];
            else
                nxt_acc[c] = acc[c];
            if (is_avg)
                res[c*DATA_W +: DATA_W] = DATA_W'(nxt_acc[c] >>> eff_len);
            else
                res[c*DATA_W +: DATA_W] = DATA_W'(nxt_acc[c]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt     <= '0;
            mode_q  <= 2'b00;
            len_q   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_busy  <= 1'b0;
            for (int c = 0; c < CH; c++)
                acc[c] <= '0;
        end else begin
            o_valid <= 1'b0;
            if (i_flush) begin
                cnt    <= '0;
                o_busy <= 1'b0;
            end else if (i_valid) begin
                if (first) begin
                    mode_q <= i_mode;
                    len_q  <= cfg_len;
                end
                if (bypass) begin
                    cnt     <= '0;
                    o_busy  <= 1'b0;
                    o_valid <= 1'b1;
                    o_data  <= i_data;
                end else begin
                    for (int c = 0; c < CH; c++)
                        acc[c] <= nxt_acc[c];
                    if (last) begin
                        cnt     <= '0;
                        o_busy  <= 1'b0;
                        o_valid <= 1'b1;
                        o_data  <= res;
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        o_busy <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/maxpool_accum.md
# maxpool_accum

Parametrised multi-channel pooling accumulator that sits after the PE-array result bus and reduces a window of consecutive result beats to one pooled beat per channel. It supports max-pooling, average-pooling (power-of-two windows) and bypass. Windows are counted internally, so no external per-window clear strobe is needed. Output is a registered single-cycle valid pulse per completed window.

## Interface
- DATA_W, 32: signed width of one channel element.
- CH, 4: number of parallel channels packed on the data buses.
- MAX_LOG2, 4: largest window is 2^MAX_LOG2 beats; LOG_W = $clog2(MAX_LOG2+1).
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_mode  in  2  00 bypass, 01 max, 10 average, 11 reserved (treated as bypass).
- i_win_log2  in  LOG_W  window length = 2^i_win_log2 beats; values > MAX_LOG2 clamp to MAX_LOG2.
- i_valid  in  1  input beat present; always accepted (no backpressure).
- i_data  in  CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W], signed.
- i_flush  in  1  abort the current partial window, discard it.
- o_valid  out  1  one-cycle pulse, pooled beat on o_data.
- o_data  out  CH*DATA_W  pooled result, same packing as i_data.
- o_busy  out  1  high while a window is partially accumulated (beat count ≠ 0).

## Operation
- Per channel: accumulator acc[c], width DATA_W+MAX_LOG2, signed. Shared beat counter cnt, width MAX_LOG2+1.
- Config latch: i_mode and i_win_log2 (clamped) are captured into mode_q/len_q on an accepted beat while cnt==0. They are held for the rest of the window. Changes mid-window are ignored.
- Window start (cnt==0, i_valid): acc[c] loads sign-extended i_data[c] with no compare. This covers the all-negative-input case; it never compares against 0 or stale data.
- Subsequent beats, max mode: acc[c] ← i_data[c] if i_data[c] > acc[c] (signed), else holds. Equal values hold.
- Subsequent beats, average mode: acc[c] ← acc[c] + i_data[c]. The width guarantees no overflow for up to 2^MAX_LOG2 beats.
- cnt increments per accepted beat. On the beat where cnt == 2^len_q − 1 (the last beat), cnt returns to 0 and the result is emitted.
- Emitted value, max: final max truncated to DATA_W. This is lossless because every operand fits DATA_W.
- Emitted value, average: (acc + new beat) >>> len_q, arithmetic shift, truncated to DATA_W. Rounding is toward −∞.
- Window length 1 (len_q=0): every beat is emitted unchanged in max or average mode.
- Bypass mode: each accepted beat is emitted directly; cnt stays 0, acc is unused, o_busy stays 0.
- i_flush: cnt ← 0 and the partial acc is discarded; no o_valid is produced for it. Flush has priority over a same-cycle i_valid: that beat is dropped as well.
- i_valid low: no state change.

## Timing
- Reset values: o_valid=0, o_data=0, o_busy=0, cnt=0, acc=0, mode_q=00, len_q=0.
- Latency: o_valid/o_data are registered one cycle after the edge that accepts the last beat of a window (bypass: one cycle after each beat).
- o_data holds its last value between pulses; o_valid is high exactly one cycle per window.
- Back-to-back windows with no gap: the last beat of window N and the first beat of window N+1 may be on consecutive cycles. Throughput is one beat per cycle sustained.
- o_busy is registered and reflects cnt≠0 after each edge.
- Reset asserted mid-window: all state returns to reset values on that edge. A pending output that was not yet registered is lost. The next accepted beat starts a fresh window.

## Test plan
- Max mode, CH=4, win_log2=2: channel 0 sees beats −5, −9, −2, −7 -> one o_valid, 1 cycle after the 4th beat, with ch0 = −2 (proves no compare against 0). Other channels carry distinct patterns and are checked independently.
- Average mode, win_log2=1: ch0 beats 3, 4 -> 3 (7>>>1). Beats −3, −4 -> −4 (floor).
- Flush: max mode, win_log2=2; send 2 beats, then i_flush together with a third valid beat, then 4 beats 1, 8, 2, 3 -> single o_valid with 8. o_busy is 0 after the flush edge.
- Back-to-back: average mode, win_log2=2, 12 continuous beats 1..12 -> o_valid pulses carrying 2, 6, 10, each exactly 4 cycles apart.
- Config change mid-window: start in max mode, switch i_mode to average after beat 1 -> that window completes as max. The next window uses average.
- Reset mid-window and bypass: assert i_rst after 3 of 4 beats -> no o_valid, all outputs 0. Then bypass mode, beats 7, −1 -> o_valid on two consecutive cycles with 7, −1.
